// File: rtl/bram_axis_reader_if.sv
// AXI4-Stream bundle carrying one 32-bit lane from the BRAM reader.
// Ports: tvalid/tdata/tstrb/tlast (master out), tready (master in).
interface bram_axis_reader_if #(
    parameter int DW = 32
);
    logic            tvalid;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic            tlast;
    logic            tready;

    modport master (
        output tvalid,
        output tdata,
        output tstrb,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tstrb,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/bram_axis_reader.sv
// Reads wide BRAM lines [start..bound] and serializes them word 0 first
// onto an AXI4-Stream master, with tlast on the final word of the final line.
// Ports: clk, rst (sync, active high); start, bram_start_addr,
// bram_bound_addr (request); busy, done, err (status); BRAM_EN, BRAM_ADDR,
// BRAM_OUT (1-cycle-latency BRAM read port); m_axis (stream master).
module bram_axis_reader #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DEPTH           = 12,
    parameter int BRAM_WIDTH_IN_WORD   = 36,
    parameter int BRAM_WIDTH           = C_M_AXIS_TDATA_WIDTH * BRAM_WIDTH_IN_WORD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BRAM_DEPTH-1:0] bram_start_addr,
    input  logic [BRAM_DEPTH-1:0] bram_bound_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  BRAM_EN,
    output logic [BRAM_DEPTH-1:0] BRAM_ADDR,
    input  logic [BRAM_WIDTH-1:0] BRAM_OUT,
    bram_axis_reader_if.master    m_axis
);
    localparam int DW = C_M_AXIS_TDATA_WIDTH;
    localparam int W  = BRAM_WIDTH_IN_WORD;
    localparam int PW = (W > 1) ? $clog2(W) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BRAM_DEPTH-1:0] r_addr;
    logic [BRAM_DEPTH-1:0] r_bound;
    logic [BRAM_WIDTH-1:0] r_buf;
    logic [PW-1:0]         r_ptr;
    logic                  r_err;

    logic w_idle;
    logic w_accept;
    logic w_reject;
    logic w_beat;
    logic w_last_word;
    logic w_last_line;

    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = w_idle && start &&
                         (bram_bound_addr >= bram_start_addr);
    assign w_reject    = w_idle && start &&
                         (bram_bound_addr < bram_start_addr);
    assign w_beat      = (r_state == S_STREAM) && m_axis.tready;
    assign w_last_word = (r_ptr == LAST_PTR);
    // Compared before any increment, so the top line never wraps to 0.
    assign w_last_line = (r_addr == r_bound);

    assign BRAM_ADDR    = r_addr;
    assign err          = r_err;
    assign m_axis.tdata = r_buf[int'(r_ptr)*DW +: DW];
    assign m_axis.tstrb = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        busy          = 1'b1;
        BRAM_EN       = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tlast  = 1'b0;
        // A rejected request reports done together with err.
        done          = r_err;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                BRAM_EN = 1'b1;
                w_next  = S_LATCH;
            end
            S_LATCH: begin
                w_next = S_STREAM;
            end
            S_STREAM: begin
                m_axis.tvalid = 1'b1;
                m_axis.tlast  = w_last_word && w_last_line;
                if (w_beat && w_last_word) begin
                    w_next = w_last_line ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_bound <= '0;
            r_buf   <= '0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_reject;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= bram_start_addr;
                        r_bound <= bram_bound_addr;
                    end
                end
                S_LATCH: begin
                    r_buf <= BRAM_OUT;
                    r_ptr <= '0;
                end
                S_STREAM: begin
                    // ptr and data hold while tready is low.
                    if (w_beat) begin
                        if (!w_last_word) begin
                            r_ptr <= r_ptr + 1'b1;
                        end else if (!w_last_line) begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bram_axis_reader.sv
// Randomized and directed bench for bram_axis_reader with W=4, depth 4.
// BRAM line k holds words k*16+j; expectations come from a line/word model.
module tb_bram_axis_reader;
    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int BW    = DW * W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DEPTH-1:0] sa;
    logic [DEPTH-1:0] ba;
    logic             busy;
    logic             done;
    logic             err;
    logic             bram_en;
    logic [DEPTH-1:0] bram_addr;
    logic [BW-1:0]    bram_out;

    int n_checks = 0;
    int n_errors = 0;

    bram_axis_reader_if #(.DW(DW)) axis ();

    bram_axis_reader #(
        .C_M_AXIS_TDATA_WIDTH(DW),
        .BRAM_DEPTH(DEPTH),
        .BRAM_WIDTH_IN_WORD(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bram_start_addr(sa),
        .bram_bound_addr(ba),
        .busy(busy),
        .done(done),
        .err(err),
        .BRAM_EN(bram_en),
        .BRAM_ADDR(bram_addr),
        .BRAM_OUT(bram_out),
        .m_axis(axis)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) begin
            for (int j = 0; j < W; j++) begin
                bram_out[j*DW +: DW] <= DW'(int'(bram_addr) * 16 + j);
            end
        end
    end

    logic [DW-1:0] got_d[$];
    bit            got_l[$];
    int            got_c[$];
    int            addr_q[$];
    int            done_n;
    int            done_cyc;
    int            err_n;
    int            err_cyc;
    int            busy_n;
    int            stall_bad;

    // Count beats that differ from the line-by-line reference sequence.
    function automatic int beat_diffs(input int s, input int b);
        int n = 0;
        int k = 0;
        for (int ln = s; ln <= b; ln++) begin
            for (int w = 0; w < W; w++) begin
                logic [DW-1:0] e;
                bit el;
                e  = DW'(ln * 16 + w);
                el = (ln == b) && (w == W - 1);
                if (k >= got_d.size()) n++;
                else if (got_d[k] !== e || got_l[k] !== el) n++;
                k++;
            end
        end
        if (got_d.size() > k) n += got_d.size() - k;
        return n;
    endfunction

    function automatic int addr_diffs(input int s, input int b);
        int n = 0;
        if (addr_q.size() != b - s + 1) return 1000 + addr_q.size();
        foreach (addr_q[i]) if (addr_q[i] != s + i) n++;
        return n;
    endfunction

    // mode 0: tready=1; mode 1: 1,0,0,1 pattern; mode 2: random.
    task automatic run(input int s, input int b, input int mode,
                       input bit poke, input int max_beats);
        bit            pst;
        logic [DW-1:0] pd;
        logic          pl;
        got_d.delete(); got_l.delete(); got_c.delete(); addr_q.delete();
        done_n = 0; done_cyc = -1; err_n = 0; err_cyc = -1;
        busy_n = 0; stall_bad = 0;
        pst = 1'b0; pd = '0; pl = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) || (poke && c == 5);
            sa    = (poke && c == 5) ? DEPTH'(0)  : DEPTH'(s);
            ba    = (poke && c == 5) ? DEPTH'(15) : DEPTH'(b);
            unique case (mode)
                0: axis.tready = 1'b1;
                1: axis.tready = (c % 4 == 0) || (c % 4 == 3);
                default: axis.tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (busy) busy_n++;
            if (bram_en) addr_q.push_back(int'(bram_addr));
            if (done) begin done_n++; done_cyc = c; end
            if (err) begin err_n++; err_cyc = c; end
            if (pst && (!axis.tvalid || axis.tdata !== pd ||
                        axis.tlast !== pl)) stall_bad++;
            if (axis.tvalid && axis.tready) begin
                got_d.push_back(axis.tdata);
                got_l.push_back(axis.tlast);
                got_c.push_back(c);
            end
            pst = axis.tvalid && !axis.tready;
            pd  = axis.tdata;
            pl  = axis.tlast;
            if (max_beats > 0 && got_d.size() == max_beats) break;
            if (done_n > 0 && c >= done_cyc + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sa = '0; ba = '0; axis.tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, err, bram_en, axis.tvalid, axis.tlast} !== 6'b0)
            $display("FAIL reset_ctrl got %b want 000000",
                     {busy, done, err, bram_en, axis.tvalid, axis.tlast});
        n_checks++;
        if (bram_addr !== '0) begin
            n_errors++;
            $display("FAIL reset_addr got %0d want 0", bram_addr);
        end
        n_checks++;
        if (axis.tdata !== '0) begin
            n_errors++;
            $display("FAIL reset_tdata got %h want 0", axis.tdata);
        end
        n_checks++;
        if (axis.tstrb !== 4'hF) begin
            n_errors++;
            $display("FAIL reset_tstrb got %h want f", axis.tstrb);
        end
        if ({busy, done, err, bram_en, axis.tvalid, axis.tlast} !== 6'b0)
            n_errors++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        int bad;
        run(2, 2, 0, 1'b0, 0);
        n_checks++;
        bad = beat_diffs(2, 2);
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL single_beats got %0d diffs want 0", bad);
        end
        n_checks++;
        if (got_c.size() == 0 || got_c[0] != 3) begin
            n_errors++;
            $display("FAIL single_first_valid got %0d want 3",
                     got_c.size() ? got_c[0] : -1);
        end
        n_checks++;
        if (done_n != 1 || done_cyc != W + 3) begin
            n_errors++;
            $display("FAIL single_done got n=%0d cyc=%0d want n=1 cyc=%0d",
                     done_n, done_cyc, W + 3);
        end
        n_checks++;
        bad = addr_diffs(2, 2);
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL single_addr got %0d diffs want 0", bad);
        end
    endtask

    task automatic test_multi();
        int bad;
        run(5, 7, 0, 1'b0, 0);
        n_checks++;
        bad = beat_diffs(5, 7);
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL multi_beats got %0d diffs want 0", bad);
        end
        n_checks++;
        bad = 0;
        foreach (got_c[i]) if (got_c[i] != 3 + i + 2 * (i / W)) bad++;
        if (bad !== 0 || got_c.size() != 3 * W) begin
            n_errors++;
            $display("FAIL multi_timing got %0d late beats of %0d want 0 of %0d",
                     bad, got_c.size(), 3 * W);
        end
        n_checks++;
        bad = addr_diffs(5, 7);
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL multi_addr got %0d diffs want 0", bad);
        end
        n_checks++;
        if (done_n != 1 || done_cyc != 3 * (W + 2) + 1) begin
            n_errors++;
            $display("FAIL multi_done got n=%0d cyc=%0d want n=1 cyc=%0d",
                     done_n, done_cyc, 3 * (W + 2) + 1);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        run(5, 7, 1, 1'b0, 0);
        n_checks++;
        bad = beat_diffs(5, 7);
        if (bad !== 0 || got_d.size() != 12) begin
            n_errors++;
            $display("FAIL bp_beats got %0d diffs %0d beats want 0 diffs 12 beats",
                     bad, got_d.size());
        end
        n_checks++;
        if (stall_bad !== 0) begin
            n_errors++;
            $display("FAIL bp_stall got %0d unstable cycles want 0", stall_bad);
        end
        n_checks++;
        bad = addr_diffs(5, 7);
        if (bad !== 0 || done_n != 1) begin
            n_errors++;
            $display("FAIL bp_addr_done got %0d diffs done=%0d want 0 and 1",
                     bad, done_n);
        end
    endtask

    task automatic test_boundary();
        int bad;
        run(15, 15, 0, 1'b0, 0);
        n_checks++;
        bad = beat_diffs(15, 15);
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL top_beats got %0d diffs want 0", bad);
        end
        n_checks++;
        bad = addr_diffs(15, 15);
        if (bad !== 0 || done_cyc != W + 3) begin
            n_errors++;
            $display("FAIL top_addr got %0d diffs done_cyc=%0d want 0 and %0d",
                     bad, done_cyc, W + 3);
        end
        run(9, 3, 0, 1'b0, 0);
        n_checks++;
        if (got_d.size() != 0 || addr_q.size() != 0) begin
            n_errors++;
            $display("FAIL err_beats got %0d beats %0d reads want 0 0",
                     got_d.size(), addr_q.size());
        end
        n_checks++;
        if (err_n != 1 || err_cyc != 1 || done_n != 1 || done_cyc != 1) begin
            n_errors++;
            $display("FAIL err_pulse got err %0d@%0d done %0d@%0d want 1@1 1@1",
                     err_n, err_cyc, done_n, done_cyc);
        end
        n_checks++;
        if (busy_n != 0) begin
            n_errors++;
            $display("FAIL err_busy got %0d busy cycles want 0", busy_n);
        end
    endtask

    task automatic test_ignore();
        int bad;
        run(5, 7, 0, 1'b1, 0);
        n_checks++;
        bad = beat_diffs(5, 7) + addr_diffs(5, 7);
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL ignore_beats got %0d diffs want 0", bad);
        end
        n_checks++;
        if (done_n != 1 || busy_n != 3 * (W + 2) + 1) begin
            n_errors++;
            $display("FAIL ignore_busy got done=%0d busy=%0d want 1 %0d",
                     done_n, busy_n, 3 * (W + 2) + 1);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        int act;
        run(5, 7, 0, 1'b0, 6);
        n_checks++;
        if (got_d.size() != 6) begin
            n_errors++;
            $display("FAIL rstmid_pre got %0d beats want 6", got_d.size());
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({axis.tvalid, busy, done, axis.tlast, bram_en} !== 5'b0 ||
            axis.tdata !== '0) begin
            n_errors++;
            $display("FAIL rstmid_state got %b tdata %h want 00000 0",
                     {axis.tvalid, busy, done, axis.tlast, bram_en}, axis.tdata);
        end
        act = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (axis.tvalid || busy || done) act++;
        end
        n_checks++;
        if (act != 0) begin
            n_errors++;
            $display("FAIL rstmid_quiet got %0d active cycles want 0", act);
        end
        run(1, 1, 0, 1'b0, 0);
        n_checks++;
        bad = beat_diffs(1, 1);
        if (bad !== 0 || done_n != 1) begin
            n_errors++;
            $display("FAIL rstmid_restart got %0d diffs done=%0d want 0 1",
                     bad, done_n);
        end
    endtask

    task automatic test_random();
        int s;
        int b;
        int bad;
        for (int it = 0; it < 8; it++) begin
            s = $urandom_range(0, 15);
            b = $urandom_range(s, 15);
            run(s, b, 2, 1'b0, 0);
            n_checks++;
            bad = beat_diffs(s, b) + addr_diffs(s, b) + stall_bad;
            if (bad !== 0 || done_n != 1 || err_n != 0) begin
                n_errors++;
                $display("FAIL rand_%0d_%0d got %0d diffs done=%0d err=%0d want 0 1 0",
                         s, b, bad, done_n, err_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_boundary();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bram_axis_reader.md
Name: bram_axis_reader

Overview:
- Read-only counterpart of the AXIS-to-BRAM write path.
- On a start pulse it reads BRAM lines from a start index to a bound index, both inclusive. Each line is BRAM_WIDTH_IN_WORD 32-bit words wide.
- Each line is serialized word 0 first onto an AXI4-Stream master. m_axis_tlast is asserted on the final word of the final line.
- It sits between the shared wide BRAM and the M00 stream output and replaces the read half of the combined controller.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, stream word width; also the width of one BRAM lane.
- BRAM_DEPTH, 12, BRAM address width in bits.
- BRAM_WIDTH_IN_WORD, 36, number of words per BRAM line.
- BRAM_WIDTH, C_M_AXIS_TDATA_WIDTH*BRAM_WIDTH_IN_WORD, BRAM line width (1152 by default).

Ports:
- clk  in  1  single clock for BRAM and stream.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- bram_start_addr  in  BRAM_DEPTH  first line index.
- bram_bound_addr  in  BRAM_DEPTH  last line index, inclusive.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a transfer.
- err  out  1  one-cycle pulse when bound < start.
- BRAM_EN  out  1  BRAM read enable.
- BRAM_ADDR  out  BRAM_DEPTH  BRAM line index.
- BRAM_OUT  in  BRAM_WIDTH  BRAM read data; read latency is 1 cycle.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tdata  out  C_M_AXIS_TDATA_WIDTH  stream data.
- m_axis_tstrb  out  C_M_AXIS_TDATA_WIDTH/8  constant all ones.
- m_axis_tlast  out  1  last word of the transfer.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset values: busy, done, err, BRAM_EN, m_axis_tvalid and m_axis_tlast are 0. BRAM_ADDR, the line buffer and the word pointer are 0, so m_axis_tdata is 0. State is IDLE.
- State machine: IDLE -> READ -> LATCH -> STREAM -> (READ | DONE) -> IDLE.
- IDLE:
  - start=1 and bound >= start: latch both indices, set addr = start, go to READ.
  - start=1 and bound < start: err=1 and done=1 on the next cycle, no beats, stay in IDLE.
- READ (1 cycle): BRAM_EN=1, BRAM_ADDR=addr; go to LATCH.
- LATCH (1 cycle): buffer <= BRAM_OUT, ptr <= 0; go to STREAM. BRAM_EN=0.
- STREAM:
  - m_axis_tvalid=1 and m_axis_tdata = buffer[ptr*32 +: 32].
  - m_axis_tlast = (ptr == BRAM_WIDTH_IN_WORD-1) && (addr == bound).
  - A beat completes only when tvalid && tready.
  - On a beat with ptr < W-1: ptr++.
  - On a beat with ptr == W-1 and addr != bound: addr++, go to READ.
  - On a beat with ptr == W-1 and addr == bound: go to DONE.
- Stall: while tvalid=1 and tready=0, tdata, tlast and ptr hold. tvalid never drops without a beat, except on rst.
- DONE (1 cycle): done=1, busy=1, tvalid=0; go to IDLE.
- Latency:
  - start sampled at edge N -> BRAM_EN high in cycle N+1 -> first tvalid in cycle N+3.
  - Each additional line costs 2 bubble cycles with tvalid=0.
  - With tready held at 1, a transfer of L lines takes L*(W+2)+1 cycles from start to done.
- start while busy is ignored; the inputs are re-sampled only in IDLE.
- The address compare happens before increment, so bound = 2^BRAM_DEPTH-1 never wraps to 0. start == bound gives exactly one line.
- rst mid-transfer: at the next edge, all outputs go to their reset values. No done pulse, no tlast; any partial packet is abandoned.
- BRAM_EN is high only in READ. There is no BRAM write port.

Test Plan:
- Bench parameters W=4, BRAM_DEPTH=4, BRAM line k preloaded with words {k*16+3, k*16+2, k*16+1, k*16+0}, with word 0 in the LSBs.
- Single line: start=1, start=bound=2, tready=1 -> tdata 0x20,0x21,0x22,0x23; tlast only on 0x23; first tvalid 3 cycles after start; done 1 cycle after the last beat.
- Multi-line: start=5, bound=7, tready=1 -> 12 beats 0x50..0x53, 0x60..0x63, 0x70..0x73; tvalid low for exactly 2 cycles between lines; BRAM_ADDR sequence 5,6,7; tlast only on 0x73.
- Backpressure: the multi-line case with tready toggling 1,0,0,1 -> identical beat sequence; tdata stable during every stall; beat count still 12.
- Boundary: start=15, bound=15 -> 4 beats 0xF0..0xF3, no address wrap. start=9, bound=3 -> err and done pulse, zero beats, busy stays 0.
- Reset and ignore: start pulsed again while busy -> no effect. rst asserted after the 6th beat of start=5, bound=7 -> next cycle tvalid=0, busy=0, no done. A fresh start=1, bound=1 then streams 0x10..0x13 correctly.
